// File: rtl/sw_array_core_pkg.sv
// Shared defaults, FSM encoding and score arithmetic helpers for the
// Smith-Waterman systolic array.
package sw_array_core_pkg;

    localparam int PE_NUM_DEF    = 16;
    localparam int CALC_BIT_DEF  = 12;
    localparam int MATCH_BIT_DEF = 4;
    localparam int CHAR_BIT_DEF  = 2;
    localparam int POS_BIT_DEF   = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Width-independent so any CALC_BIT can share it; callers pass their ceiling.
    function automatic int sat_add(input int a, input int b, input int max_val);
        int sum;
        sum = a + b;
        return (sum > max_val) ? max_val : sum;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sw_affine_pe.sv
// One affine-gap Smith-Waterman cell: holds a query symbol and scores each
// target symbol that passes through, forwarding H/F and the column max.
module sw_affine_pe
    import sw_array_core_pkg::*;
#(
    parameter int CALC_BIT  = CALC_BIT_DEF,
    parameter int MATCH_BIT = MATCH_BIT_DEF,
    parameter int CHAR_BIT  = CHAR_BIT_DEF,
    parameter int POS_BIT   = POS_BIT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       q_we,
    input  logic [CHAR_BIT-1:0]        q_char,
    input  logic                       active,
    input  logic [MATCH_BIT-1:0]       match,
    input  logic [MATCH_BIT-1:0]       mismatch,
    input  logic [MATCH_BIT-1:0]       alpha,
    input  logic [MATCH_BIT-1:0]       beta,
    input  logic                       in_valid,
    input  logic [CHAR_BIT-1:0]        in_char,
    input  logic [POS_BIT-1:0]         in_pos,
    input  logic signed [CALC_BIT-1:0] in_h,
    input  logic signed [CALC_BIT-1:0] in_f,
    input  logic signed [CALC_BIT-1:0] in_max,
    output logic                       out_valid,
    output logic [CHAR_BIT-1:0]        out_char,
    output logic [POS_BIT-1:0]         out_pos,
    output logic signed [CALC_BIT-1:0] out_h,
    output logic signed [CALC_BIT-1:0] out_f,
    output logic signed [CALC_BIT-1:0] out_max
);

    localparam int SCORE_MAX = 2 ** (CALC_BIT - 1) - 1;

    logic [CHAR_BIT-1:0]        q;
    logic signed [CALC_BIT-1:0] h_own;
    logic signed [CALC_BIT-1:0] e_own;
    logic signed [CALC_BIT-1:0] h_diag;
    int                         sub;
    int                         e_new;
    int                         f_new;
    int                         h_new;

    always_comb begin
        sub   = (in_char == q) ? int'(match) : -int'(mismatch);
        e_new = max2(sat_add(int'(h_own), -int'(alpha), SCORE_MAX),
                     sat_add(int'(e_own), -int'(beta), SCORE_MAX));
        f_new = max2(sat_add(int'(in_h), -int'(alpha), SCORE_MAX),
                     sat_add(int'(in_f), -int'(beta), SCORE_MAX));
        h_new = max2(0, max2(max2(e_new, f_new),
                             sat_add(int'(h_diag), sub, SCORE_MAX)));
    end

    // h_diag keeps the upstream H of the previous column, i.e. H(i-1,j-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            h_own     <= '0;
            e_own     <= '0;
            h_diag    <= '0;
            out_valid <= 1'b0;
            out_char  <= '0;
            out_pos   <= '0;
            out_h     <= '0;
            out_f     <= '0;
            out_max   <= '0;
        end else begin
            if (q_we)
                q <= q_char;
            out_valid <= in_valid;
            if (clear) begin
                h_own  <= '0;
                e_own  <= '0;
                h_diag <= '0;
            end else if (in_valid) begin
                h_own    <= CALC_BIT'(h_new);
                e_own    <= CALC_BIT'(e_new);
                h_diag   <= in_h;
                out_char <= in_char;
                out_pos  <= in_pos;
                out_h    <= CALC_BIT'(h_new);
                out_f    <= CALC_BIT'(f_new);
                out_max  <= (active && (h_new > int'(in_max))) ? CALC_BIT'(h_new) : in_max;
            end
        end
    end

endmodule

// File: rtl/sw_array_core.sv
// Smith-Waterman scoring core: job FSM, query loader, parameter latch,
// systolic PE chain and best-score tracker.
module sw_array_core
    import sw_array_core_pkg::*;
#(
    parameter int PE_NUM    = PE_NUM_DEF,
    parameter int CALC_BIT  = CALC_BIT_DEF,
    parameter int MATCH_BIT = MATCH_BIT_DEF,
    parameter int CHAR_BIT  = CHAR_BIT_DEF,
    parameter int POS_BIT   = POS_BIT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic [MATCH_BIT-1:0]       match_i,
    input  logic [MATCH_BIT-1:0]       mismatch_i,
    input  logic [MATCH_BIT-1:0]       alpha_i,
    input  logic [MATCH_BIT-1:0]       beta_i,
    input  logic                       q_valid_i,
    input  logic [CHAR_BIT-1:0]        q_char_i,
    input  logic                       q_last_i,
    output logic                       q_ready_o,
    input  logic                       t_valid_i,
    input  logic [CHAR_BIT-1:0]        t_char_i,
    input  logic                       t_last_i,
    output logic                       t_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic signed [CALC_BIT-1:0] max_score_o,
    output logic [POS_BIT-1:0]         max_pos_o,
    output logic                       err_qlen_o
);

    localparam int QW = $clog2(PE_NUM + 1);

    state_t                     state;
    state_t                     state_nx;
    logic                       mode;
    logic [MATCH_BIT-1:0]       match;
    logic [MATCH_BIT-1:0]       mismatch;
    logic [MATCH_BIT-1:0]       alpha;
    logic [MATCH_BIT-1:0]       beta;
    logic [QW-1:0]              q_cnt;
    logic [QW-1:0]              drain_cnt;
    logic                       err;
    logic [POS_BIT-1:0]         pos_cnt;
    logic                       start_hs;
    logic                       q_hs;
    logic                       t_hs;
    logic                       in_valid;
    logic [CHAR_BIT-1:0]        in_char;
    logic [POS_BIT-1:0]         in_pos;
    logic signed [CALC_BIT-1:0] best_score;
    logic [POS_BIT-1:0]         best_pos;
    logic                       tap_valid;
    logic signed [CALC_BIT-1:0] tap_score;
    logic [POS_BIT-1:0]         tap_pos;

    logic                       ch_valid [PE_NUM+1];
    logic [CHAR_BIT-1:0]        ch_char  [PE_NUM+1];
    logic [POS_BIT-1:0]         ch_pos   [PE_NUM+1];
    logic signed [CALC_BIT-1:0] ch_h     [PE_NUM+1];
    logic signed [CALC_BIT-1:0] ch_f     [PE_NUM+1];
    logic signed [CALC_BIT-1:0] ch_max   [PE_NUM+1];

    assign start_hs = (state == S_IDLE) && start_i;
    assign q_hs     = (state == S_LOAD) && q_valid_i;
    assign t_hs     = (state == S_RUN) && t_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_i) state_nx = S_LOAD;
            S_LOAD:  if (q_valid_i && q_last_i) state_nx = S_RUN;
            S_RUN:   if (t_valid_i && t_last_i) state_nx = S_DRAIN;
            S_DRAIN: if (drain_cnt == q_cnt) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        q_ready_o = (state == S_LOAD);
        t_ready_o = (state == S_RUN);
        busy_o    = (state != S_IDLE);
        done_o    = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode       <= 1'b0;
            match      <= '0;
            mismatch   <= '0;
            alpha      <= '0;
            beta       <= '0;
            q_cnt      <= '0;
            drain_cnt  <= '0;
            err        <= 1'b0;
            pos_cnt    <= '0;
            in_valid   <= 1'b0;
            in_char    <= '0;
            in_pos     <= '0;
            best_score <= '0;
            best_pos   <= '0;
        end else begin
            if (q_hs) begin
                if (q_cnt == QW'(PE_NUM))
                    err <= 1'b1;
                else
                    q_cnt <= q_cnt + 1'b1;
            end
            if (state == S_RUN)
                drain_cnt <= '0;
            else if (state == S_DRAIN)
                drain_cnt <= drain_cnt + 1'b1;
            in_valid <= t_hs;
            if (t_hs) begin
                in_char <= t_char_i;
                in_pos  <= pos_cnt;
                pos_cnt <= pos_cnt + 1'b1;
            end
            // Strictly greater so that ties keep the earliest target position.
            if (tap_valid && (tap_score > best_score)) begin
                best_score <= tap_score;
                best_pos   <= tap_pos;
            end
            if (start_hs) begin
                mode       <= mode_i;
                match      <= match_i;
                mismatch   <= mismatch_i;
                alpha      <= alpha_i;
                beta       <= beta_i;
                q_cnt      <= '0;
                err        <= 1'b0;
                pos_cnt    <= '0;
                best_score <= '0;
                best_pos   <= '0;
            end
        end
    end

    assign ch_valid[0] = in_valid;
    assign ch_char[0]  = in_char;
    assign ch_pos[0]   = in_pos;
    assign ch_h[0]     = '0;
    assign ch_f[0]     = '0;
    assign ch_max[0]   = '0;

    for (genvar i = 0; i < PE_NUM; i++) begin : g_pe
        sw_affine_pe #(
            .CALC_BIT (CALC_BIT),
            .MATCH_BIT(MATCH_BIT),
            .CHAR_BIT (CHAR_BIT),
            .POS_BIT  (POS_BIT)
        ) u_pe (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (start_hs),
            .q_we     (q_hs && (q_cnt == QW'(i))),
            .q_char   (q_char_i),
            .active   (QW'(i) < q_cnt),
            .match    (match),
            .mismatch (mismatch),
            .alpha    (alpha),
            .beta     (beta),
            .in_valid (ch_valid[i]),
            .in_char  (ch_char[i]),
            .in_pos   (ch_pos[i]),
            .in_h     (ch_h[i]),
            .in_f     (ch_f[i]),
            .in_max   (ch_max[i]),
            .out_valid(ch_valid[i+1]),
            .out_char (ch_char[i+1]),
            .out_pos  (ch_pos[i+1]),
            .out_h    (ch_h[i+1]),
            .out_f    (ch_f[i+1]),
            .out_max  (ch_max[i+1])
        );
    end

    // Output of PE q_len-1 sits at chain index q_len.
    always_comb begin
        tap_valid = ch_valid[q_cnt];
        tap_pos   = ch_pos[q_cnt];
        tap_score = mode ? ch_h[q_cnt] : ch_max[q_cnt];
    end

    assign max_score_o = best_score;
    assign max_pos_o   = best_pos;
    assign err_qlen_o  = err;

endmodule

// File: tb/tb_sw_array_core.sv
// Table-driven bench for sw_array_core with a done-event scoreboard.
module tb_sw_array_core;

    localparam int PE_NUM    = 4;
    localparam int CALC_BIT  = 6;
    localparam int MATCH_BIT = 4;
    localparam int CHAR_BIT  = 2;
    localparam int POS_BIT   = 16;
    localparam int NV        = 10;

    logic                       clk;
    logic                       rst_n;
    logic                       start_i;
    logic                       mode_i;
    logic [MATCH_BIT-1:0]       match_i;
    logic [MATCH_BIT-1:0]       mismatch_i;
    logic [MATCH_BIT-1:0]       alpha_i;
    logic [MATCH_BIT-1:0]       beta_i;
    logic                       q_valid_i;
    logic [CHAR_BIT-1:0]        q_char_i;
    logic                       q_last_i;
    logic                       q_ready_o;
    logic                       t_valid_i;
    logic [CHAR_BIT-1:0]        t_char_i;
    logic                       t_last_i;
    logic                       t_ready_o;
    logic                       busy_o;
    logic                       done_o;
    logic signed [CALC_BIT-1:0] max_score_o;
    logic [POS_BIT-1:0]         max_pos_o;
    logic                       err_qlen_o;

    typedef struct {
        logic [63:0] q;
        int          qn;
        logic [63:0] t;
        int          tn;
        int          m, mm, a, b;
        bit          mode;
        bit          bub;
        int          es, ep;
        bit          ee;
        int          el;
    } vec_t;

    typedef struct {
        int score;
        int pos;
        bit err;
        int t0;
        int lat;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    sw_array_core #(
        .PE_NUM   (PE_NUM),
        .CALC_BIT (CALC_BIT),
        .MATCH_BIT(MATCH_BIT),
        .CHAR_BIT (CHAR_BIT),
        .POS_BIT  (POS_BIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .match_i    (match_i),
        .mismatch_i (mismatch_i),
        .alpha_i    (alpha_i),
        .beta_i     (beta_i),
        .q_valid_i  (q_valid_i),
        .q_char_i   (q_char_i),
        .q_last_i   (q_last_i),
        .q_ready_o  (q_ready_o),
        .t_valid_i  (t_valid_i),
        .t_char_i   (t_char_i),
        .t_last_i   (t_last_i),
        .t_ready_o  (t_ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .max_score_o(max_score_o),
        .max_pos_o  (max_pos_o),
        .err_qlen_o (err_qlen_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CHAR_BIT-1:0] enc(input logic [7:0] c);
        case (c)
            "A":     return 2'd0;
            "C":     return 2'd1;
            "G":     return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic vec_t mk(input logic [63:0] q, input int qn, input logic [63:0] t,
                                input int tn, input int m, input int mm, input int a,
                                input int b, input bit mode, input bit bub, input int es,
                                input int ep, input bit ee, input int el);
        vec_t v;
        v.q = q; v.qn = qn; v.t = t; v.tn = tn;
        v.m = m; v.mm = mm; v.a = a; v.b = b;
        v.mode = mode; v.bub = bub;
        v.es = es; v.ep = ep; v.ee = ee; v.el = el;
        return v;
    endfunction

    // Scoreboard: each done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("score", int'(max_score_o), e.score);
                check("pos", int'(max_pos_o), e.pos);
                check("err_qlen", int'(err_qlen_o), int'(e.err));
                check("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic run_job(input vec_t v);
        exp_t e;
        bit   rdy_ok;
        int   k;
        int   n;
        @(negedge clk);
        start_i    = 1'b1;
        mode_i     = v.mode;
        match_i    = 4'(v.m);
        mismatch_i = 4'(v.mm);
        alpha_i    = 4'(v.a);
        beta_i     = 4'(v.b);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < v.qn; i++) begin
            q_valid_i = 1'b1;
            q_char_i  = enc(v.q[8*(v.qn-1-i) +: 8]);
            q_last_i  = (i == v.qn - 1);
            @(negedge clk);
        end
        q_valid_i = 1'b0;
        q_last_i  = 1'b0;
        rdy_ok = 1'b1;
        k = 0;
        while (k < v.tn) begin
            if (!t_ready_o) rdy_ok = 1'b0;
            if (v.bub) begin
                // Garbage start request while busy must be ignored.
                start_i = 1'b1;
                match_i = '0;
            end
            if (v.bub && ($urandom_range(0, 2) == 0)) begin
                t_valid_i = 1'b0;
                t_last_i  = 1'b0;
            end else begin
                t_valid_i = 1'b1;
                t_char_i  = enc(v.t[8*(v.tn-1-k) +: 8]);
                t_last_i  = (k == v.tn - 1);
                if (k == v.tn - 1) begin
                    e.score = v.es; e.pos = v.ep; e.err = v.ee;
                    e.t0 = cyc; e.lat = v.el;
                    sb.push_back(e);
                end
                k++;
            end
            @(negedge clk);
        end
        t_valid_i = 1'b0;
        t_last_i  = 1'b0;
        start_i   = 1'b0;
        check("t_ready_in_run", int'(rdy_ok), 1);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
        check("idle_after_done", int'(busy_o), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0] = mk("ACGT",  4, "ACGT",  4, 2, 1, 3, 1, 1'b0, 1'b0,  8, 3, 1'b0, 6);
        vecs[1] = mk("ACGG",  4, "ACGT",  4, 2, 1, 3, 1, 1'b0, 1'b0,  6, 2, 1'b0, 6);
        vecs[2] = mk("ACGG",  4, "ACGT",  4, 2, 1, 3, 1, 1'b1, 1'b0,  5, 3, 1'b0, 6);
        vecs[3] = mk("ACGT",  4, "ACGCT", 5, 3, 1, 2, 1, 1'b0, 1'b0, 10, 4, 1'b0, 6);
        vecs[4] = mk("ACGT",  4, "ACGT",  4, 2, 1, 3, 1, 1'b0, 1'b1,  8, 3, 1'b0, 6);
        vecs[5] = mk("ACGTA", 5, "ACGT",  4, 2, 1, 3, 1, 1'b0, 1'b0,  8, 3, 1'b1, 6);
        vecs[6] = mk("A",     1, "CAG",   3, 2, 1, 3, 1, 1'b1, 1'b0,  2, 1, 1'b0, 3);
        vecs[7] = mk("ACGT",  4, "T",     1, 2, 1, 3, 1, 1'b0, 1'b0,  2, 0, 1'b0, 6);
        vecs[8] = mk("AC",    2, "ACAC",  4, 2, 1, 3, 1, 1'b1, 1'b0,  4, 1, 1'b0, 4);
        vecs[9] = mk("ACGT",  4, "ACGT",  4, 15, 1, 3, 1, 1'b0, 1'b0, 31, 2, 1'b0, 6);

        rst_n = 1'b0;
        start_i = 1'b0; mode_i = 1'b0;
        match_i = '0; mismatch_i = '0; alpha_i = '0; beta_i = '0;
        q_valid_i = 1'b0; q_char_i = '0; q_last_i = 1'b0;
        t_valid_i = 1'b0; t_char_i = '0; t_last_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({busy_o, done_o, q_ready_o, t_ready_o, err_qlen_o,
                                     max_score_o, max_pos_o}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_job(vecs[i]);

        // Abort mid-RUN: load ACGT, stream ACG, let scores settle, then reset.
        start_i = 1'b1; mode_i = 1'b0;
        match_i = 4'd2; mismatch_i = 4'd1; alpha_i = 4'd3; beta_i = 4'd1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_valid_i = 1'b1;
            q_char_i  = CHAR_BIT'(i);
            q_last_i  = (i == 3);
            @(negedge clk);
        end
        q_valid_i = 1'b0; q_last_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t_valid_i = 1'b1;
            t_char_i  = CHAR_BIT'(i);
            @(negedge clk);
        end
        t_valid_i = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_abort_score", int'(max_score_o), 6);
        check("pre_abort_t_ready", int'(t_ready_o), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_outputs", int'({busy_o, done_o, q_ready_o, t_ready_o, err_qlen_o,
                                     max_score_o, max_pos_o}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
